// File: rtl/mem_stage.sv
// MEM pipeline stage: issues data-memory loads/stores, lane-selects and extends load data,
// and registers the MEM/WB bundle. ALU ops and misaligned ops retire after 1 cycle; memory ops stall EX until ready or timeout.
module mem_stage #(
  parameter int TIMEOUT   = 16,
  parameter int TIMEOUT_W = 5
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  input  logic [31:0] alu_data,
  input  logic [31:0] rt_out,
  input  logic [4:0]  regdst_out,
  input  logic [31:0] pc_in,
  input  logic [7:0]  control_in,
  output logic        stall,
  output logic [31:0] ex_mem_data,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  output logic [3:0]  dmem_be,
  input  logic        dmem_ready,
  input  logic [31:0] dmem_rdata,
  output logic        wb_valid,
  output logic        wb_reg_write,
  output logic [4:0]  wb_dest,
  output logic [31:0] wb_data,
  output logic [31:0] wb_pc,
  output logic        mem_err
);

  typedef enum logic {IDLE, ACCESS} state_t;

  state_t               state, state_nxt;
  logic [TIMEOUT_W-1:0] cnt;

  logic [31:0] l_alu, l_rt, l_pc;
  logic [4:0]  l_dest;
  logic        l_wr, l_sub, l_half, l_uns, l_m2r, l_rw;

  // Incoming bundle decode; a store wins when both read and write are set.
  logic in_wr, in_mem, in_sub, in_mis, accept;
  assign in_wr  = control_in[5];
  assign in_mem = control_in[6] | control_in[5];
  assign in_sub = in_wr ? control_in[0] : control_in[7];
  assign in_mis = in_mem && (in_sub ? (control_in[2] && alu_data[0]) : (alu_data[1:0] != 2'b00));
  assign accept = (state == IDLE) && in_valid;

  logic timeout_hit;
  assign timeout_hit = !dmem_ready && (cnt == TIMEOUT_W'(TIMEOUT - 1));

  logic [3:0]  st_be;
  logic [31:0] st_wdata;
  always_comb begin
    st_be    = 4'b1111;
    st_wdata = l_rt;
    if (l_sub) begin
      if (l_half) begin
        st_be    = l_alu[1] ? 4'b1100 : 4'b0011;
        st_wdata = {2{l_rt[15:0]}};
      end else begin
        st_be    = 4'b0001 << l_alu[1:0];
        st_wdata = {4{l_rt[7:0]}};
      end
    end
  end

  logic [15:0] lane16;
  logic [7:0]  lane8;
  logic [31:0] ld_data;
  always_comb begin
    lane16  = l_alu[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
    lane8   = 8'h00;
    ld_data = dmem_rdata;
    case (l_alu[1:0])
      2'd0:    lane8 = dmem_rdata[7:0];
      2'd1:    lane8 = dmem_rdata[15:8];
      2'd2:    lane8 = dmem_rdata[23:16];
      default: lane8 = dmem_rdata[31:24];
    endcase
    if (l_sub) begin
      if (l_half) ld_data = {{16{~l_uns & lane16[15]}}, lane16};
      else        ld_data = {{24{~l_uns & lane8[7]}}, lane8};
    end
  end

  always_comb begin
    state_nxt  = state;
    stall      = 1'b0;
    dmem_req   = 1'b0;
    dmem_we    = 1'b0;
    dmem_addr  = 32'h0;
    dmem_wdata = 32'h0;
    dmem_be    = 4'h0;
    case (state)
      IDLE: begin
        if (in_valid && in_mem && !in_mis) begin
          state_nxt = ACCESS;
          stall     = 1'b1;
        end
      end
      ACCESS: begin
        stall      = 1'b1;
        dmem_req   = 1'b1;
        dmem_we    = l_wr;
        dmem_addr  = {l_alu[31:2], 2'b00};
        dmem_wdata = st_wdata;
        dmem_be    = l_wr ? st_be : 4'b1111;
        if (dmem_ready || timeout_hit) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      cnt          <= '0;
      l_alu        <= 32'h0;
      l_rt         <= 32'h0;
      l_pc         <= 32'h0;
      l_dest       <= 5'h0;
      l_wr         <= 1'b0;
      l_sub        <= 1'b0;
      l_half       <= 1'b0;
      l_uns        <= 1'b0;
      l_m2r        <= 1'b0;
      l_rw         <= 1'b0;
      ex_mem_data  <= 32'h0;
      wb_valid     <= 1'b0;
      wb_reg_write <= 1'b0;
      wb_dest      <= 5'h0;
      wb_data      <= 32'h0;
      wb_pc        <= 32'h0;
      mem_err      <= 1'b0;
    end else begin
      state        <= state_nxt;
      wb_valid     <= 1'b0;
      wb_reg_write <= 1'b0;
      mem_err      <= 1'b0;
      if (accept) begin
        ex_mem_data <= alu_data;
        l_alu       <= alu_data;
        l_rt        <= rt_out;
        l_pc        <= pc_in;
        l_dest      <= regdst_out;
        l_wr        <= in_wr;
        l_sub       <= in_sub;
        l_half      <= control_in[2];
        l_uns       <= control_in[1];
        l_m2r       <= control_in[4];
        l_rw        <= control_in[3];
        cnt         <= '0;
        if (!in_mem || in_mis) begin
          wb_valid     <= 1'b1;
          wb_reg_write <= control_in[3] && !in_mis;
          wb_dest      <= regdst_out;
          wb_data      <= alu_data;
          wb_pc        <= pc_in;
          mem_err      <= in_mis;
        end
      end else if (state == ACCESS) begin
        if (dmem_ready || timeout_hit) begin
          // A timed-out op retires without a register write; the store is treated as not done.
          wb_valid     <= 1'b1;
          wb_reg_write <= dmem_ready && l_rw;
          wb_dest      <= l_dest;
          wb_pc        <= l_pc;
          wb_data      <= (dmem_ready && l_m2r && !l_wr) ? ld_data : l_alu;
          mem_err      <= !dmem_ready;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end
    end
  end

endmodule
